// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and encodings for the calculator responder.
//   CALC_DATA_W / CALC_RES_W : default operand width and result width (operand + 1)
//   DIV0_RESULT              : result word returned for divide/modulo by zero
//   opcode_e                 : request opcode encoding
//   ST_IDLE / ST_EXEC / ST_RESP : responder FSM state encoding
package calc_pkg;

    localparam int unsigned CALC_DATA_W = 32;
    localparam int unsigned CALC_RES_W  = CALC_DATA_W + 1;

    localparam logic [CALC_RES_W-1:0] DIV0_RESULT = 33'h1_FFFF_FFFF;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4,
        OP_AND = 3'd5,
        OP_OR  = 3'd6,
        OP_XOR = 3'd7
    } opcode_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/calc_iter_muldiv.sv
// calc_iter_muldiv: iterative unsigned multiplier (shift-add) and restoring divider.
// Both share one 2*DATA_W working register and a 6-bit step counter; one step per cycle,
// ITER_CYCLES steps per operation.
// Ports:
//   clk, reset_high : clock and synchronous active-high reset
//   start           : load operands and begin (single-cycle pulse)
//   is_div          : 1 = divide/modulo, 0 = multiply (sampled with start)
//   a, b            : multiplicand/dividend and multiplier/divisor
//   done            : high in the cycle the final step executes; results valid next cycle
//   product_lo      : low DATA_W+1 bits of the product
//   quotient        : a / b
//   remainder       : a % b
// Results hold their value while idle.
module calc_iter_muldiv #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ITER_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset_high,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W:0]   product_lo,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam logic [5:0] LAST_STEP = 6'(ITER_CYCLES - 1);

    logic [2*DATA_W-1:0] work_q;
    logic [DATA_W-1:0]   operand_q;
    logic [5:0]          step_q;
    logic                busy_q;
    logic                div_q;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     rem_shift;
    logic                rem_ge;
    logic [DATA_W-1:0]   rem_new;
    logic [2*DATA_W-1:0] div_next;

    // Multiply: upper half accumulates, lower half holds the multiplier being shifted out.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*DATA_W-1:DATA_W]};
        if (work_q[0]) begin
            mul_sum = mul_sum + {1'b0, operand_q};
        end
        mul_next = {mul_sum, work_q[DATA_W-1:1]};
    end

    // Divide: upper half is the partial remainder, lower half shifts dividend out and
    // quotient bits in. If the subtract is skipped the shifted remainder is below the
    // divisor, so its top bit is zero and truncation is lossless.
    always_comb begin
        rem_shift = work_q[2*DATA_W-1:DATA_W-1];
        rem_ge    = rem_shift >= {1'b0, operand_q};
        if (rem_ge) begin
            rem_new = DATA_W'(rem_shift - {1'b0, operand_q});
        end else begin
            rem_new = rem_shift[DATA_W-1:0];
        end
        div_next = {rem_new, work_q[DATA_W-2:0], rem_ge};
    end

    assign done = busy_q && (step_q == LAST_STEP);

    always_ff @(posedge clk) begin
        if (reset_high) begin
            work_q    <= '0;
            operand_q <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
            div_q     <= 1'b0;
        end else if (start) begin
            work_q    <= {{DATA_W{1'b0}}, a};
            operand_q <= b;
            step_q    <= '0;
            busy_q    <= 1'b1;
            div_q     <= is_div;
        end else if (busy_q) begin
            work_q <= div_q ? div_next : mul_next;
            step_q <= step_q + 6'd1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign product_lo = work_q[DATA_W:0];
    assign quotient   = work_q[DATA_W-1:0];
    assign remainder  = work_q[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/calc_seq_responder.sv
// calc_seq_responder: responder end of the calculator request/result protocol.
// Accepts one (A, B, opcode) request per valid/ready handshake, executes it (single-cycle
// ALU ops directly, MUL/DIV/MOD iteratively) and returns a DATA_W+1 bit result plus an
// error flag (divide/modulo by zero) through a valid/ready handshake.
// Optional build macro: CALC_OP_COUNT_EN adds the op_count port (saturating count of
// response handshakes).
// Ports:
//   clk, reset_high      : clock and synchronous active-high reset
//   req_valid, req_ready : request handshake; A, B, opcode sampled on handshake
//   rsp_valid, rsp_ready : response handshake; result and rsp_err held until accepted
//   result, rsp_err      : operation result and divide-by-zero flag
//   op_count             : completed-response counter (CALC_OP_COUNT_EN only)
module calc_seq_responder
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W      = CALC_DATA_W,
    parameter int unsigned ITER_CYCLES = CALC_DATA_W
) (
    input  logic              clk,
    input  logic              reset_high,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        opcode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W:0]   result,
    output logic              rsp_err
`ifdef CALC_OP_COUNT_EN
    ,
    output logic [15:0]       op_count
`endif
);

    logic [1:0]      state_q;
    logic [2:0]      op_q;
    logic [DATA_W:0] result_q;
    logic            err_q;
    logic            use_iter_q;

    logic            req_fire;
    logic            rsp_fire;
    logic            is_iter_op;
    logic            div_by_zero;
    logic            iter_start;
    logic            iter_done;
    logic [DATA_W:0] alu_res;
    logic [DATA_W:0] iter_res;

    logic [DATA_W:0]   product_lo;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    assign is_iter_op  = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_MOD);
    assign div_by_zero = ((opcode == OP_DIV) || (opcode == OP_MOD)) && (B == '0);
    assign iter_start  = req_fire && is_iter_op && !div_by_zero;

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = {1'b0, A} + {1'b0, B};
            OP_SUB:  alu_res = {1'b0, A} - {1'b0, B};
            OP_AND:  alu_res = {1'b0, A & B};
            OP_OR:   alu_res = {1'b0, A | B};
            OP_XOR:  alu_res = {1'b0, A ^ B};
            default: alu_res = '0;
        endcase
    end

    calc_iter_muldiv #(
        .DATA_W      (DATA_W),
        .ITER_CYCLES (ITER_CYCLES)
    ) u_iter (
        .clk        (clk),
        .reset_high (reset_high),
        .start      (iter_start),
        .is_div     (opcode != OP_MUL),
        .a          (A),
        .b          (B),
        .done       (iter_done),
        .product_lo (product_lo),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always_comb begin
        iter_res = {1'b0, quotient};
        if (op_q == OP_MUL) begin
            iter_res = product_lo;
        end else if (op_q == OP_MOD) begin
            iter_res = {1'b0, remainder};
        end
    end

    always_ff @(posedge clk) begin
        if (reset_high) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            use_iter_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        op_q       <= opcode;
                        use_iter_q <= 1'b0;
                        err_q      <= div_by_zero;
                        if (div_by_zero) begin
                            result_q <= '1;
                            state_q  <= ST_RESP;
                        end else if (is_iter_op) begin
                            state_q  <= ST_EXEC;
                        end else begin
                            result_q <= alu_res;
                            state_q  <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    // The iterator's registers settle on this edge and then hold, so the
                    // result is read straight from them for the whole RESP phase.
                    if (iter_done) begin
                        use_iter_q <= 1'b1;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result  = use_iter_q ? iter_res : result_q;
    assign rsp_err = err_q;

`ifdef CALC_OP_COUNT_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk) begin
        if (reset_high) begin
            op_count_q <= '0;
        end else if (rsp_fire && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_calc_seq_responder.sv
// Self-checking bench for calc_seq_responder: behavioural model (arithmetic on 64-bit
// values plus a response countdown), per-cycle compare, directed cases and random traffic.
module tb_calc_seq_responder;

    logic        clk = 1'b0;
    logic        reset_high;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  opcode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [32:0] result;
    logic        rsp_err;
`ifdef CALC_OP_COUNT_EN
    logic [15:0] op_count;
`endif

    calc_seq_responder dut (
        .clk        (clk),
        .reset_high (reset_high),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .result     (result),
        .rsp_err    (rsp_err)
`ifdef CALC_OP_COUNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions.
    function automatic logic [32:0] exp_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [63:0] w;
        case (op)
            3'd0: w = {32'b0, a} + {32'b0, b};
            3'd1: w = {32'b0, a} - {32'b0, b};
            3'd2: w = {32'b0, a} * {32'b0, b};
            3'd3: w = (b == 0) ? 64'h1_FFFF_FFFF : {32'b0, a / b};
            3'd4: w = (b == 0) ? 64'h1_FFFF_FFFF : {32'b0, a % b};
            3'd5: w = {32'b0, a & b};
            3'd6: w = {32'b0, a | b};
            default: w = {32'b0, a ^ b};
        endcase
        return w[32:0];
    endfunction

    // Model: idle / computing (countdown) / responding.
    bit          m_busy = 1'b0;
    bit          m_resp = 1'b0;
    int          m_wait = 0;
    logic [32:0] m_result = '0;
    logic        m_err = 1'b0;
    int          m_count = 0;

    always @(posedge clk) begin
        if (reset_high) begin
            m_busy   <= 1'b0;
            m_resp   <= 1'b0;
            m_wait   <= 0;
            m_result <= '0;
            m_err    <= 1'b0;
            m_count  <= 0;
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_resp  <= 1'b0;
                m_count <= (m_count < 65535) ? m_count + 1 : m_count;
            end
        end else if (m_busy) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_busy <= 1'b0;
                m_resp <= 1'b1;
            end
        end else if (req_valid) begin
            m_result <= exp_res(A, B, opcode);
            m_err    <= (opcode == 3'd3 || opcode == 3'd4) && (B == 0);
            if ((opcode == 3'd2) || ((opcode == 3'd3 || opcode == 3'd4) && B != 0)) begin
                m_busy <= 1'b1;
                m_wait <= 32;
            end else begin
                m_resp <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, m_resp});
            chk("req_ready", {63'b0, req_ready}, {63'b0, !m_busy && !m_resp});
            if (m_resp) begin
                chk("result", {31'b0, result}, {31'b0, m_result});
                chk("rsp_err", {63'b0, rsp_err}, {63'b0, m_err});
            end
`ifdef CALC_OP_COUNT_EN
            chk("op_count", {48'b0, op_count}, 64'(m_count));
`endif
        end
    end

    // All stimulus tasks start and end at a negedge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int n = 0;
        A = a;
        B = b;
        opcode = op;
        req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_timeout", {63'b0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", {63'b0, rsp_valid}, 64'd1);
    endtask

    task automatic ack(input int stall);
        rsp_ready = 1'b0;
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input int stall, input int exp_lat, input logic [32:0] exp_val);
        int lat;
        send(a, b, op);
        wait_rsp(lat);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("literal_result", {31'b0, result}, {31'b0, exp_val});
        ack(stall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        reset_high = 1'b1;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        A = '0;
        B = '0;
        opcode = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_result", {31'b0, result}, 64'd0);
        chk("reset_err", {63'b0, rsp_err}, 64'd0);
        chk("reset_req_ready", {63'b0, req_ready}, 64'd1);
        chk("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        reset_high = 1'b0;
        @(negedge clk);

        // Pin the reference arithmetic to hand-computed values.
        chk("model_add", {31'b0, exp_res(32'hFFFF_FFFF, 32'd1, 3'd0)}, 64'h1_0000_0000);
        chk("model_sub", {31'b0, exp_res(32'd0, 32'd1, 3'd1)}, 64'h1_FFFF_FFFF);
        chk("model_mul", {31'b0, exp_res(32'd12345, 32'd678, 3'd2)}, 64'd8369910);
        chk("model_div", {31'b0, exp_res(32'd100, 32'd7, 3'd3)}, 64'd14);
        chk("model_mod", {31'b0, exp_res(32'd100, 32'd7, 3'd4)}, 64'd2);

        // Request held during EXEC with A changing; accepted only after the response.
        send(32'h0000_DEAD, 32'h0000_1234, 3'd2);
        req_valid = 1'b1;
        opcode = 3'd0;
        B = 32'd5;
        for (int i = 0; i < 100 && !req_ready; i++) begin
            A = $urandom;
            if (rsp_valid) chk("held_first", {31'b0, result}, 64'd265643300);
            rsp_ready = rsp_valid;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        if (!req_ready) chk("held_timeout", {63'b0, req_ready}, 64'd1);
        A = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat);
        chk("held_second", {31'b0, result}, 64'h15);
        ack(0);
`ifdef CALC_OP_COUNT_EN
        chk("op_count_two", {48'b0, op_count}, 64'd2);
`endif

        // ADD with backpressure: result must hold for 5 cycles.
        send(32'hFFFF_FFFF, 32'd1, 3'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'b0, rsp_valid}, 64'd1);
            chk("bp_result", {31'b0, result}, 64'h1_0000_0000);
            @(negedge clk);
        end
        ack(0);
        chk("bp_idle", {63'b0, req_ready}, 64'd1);

        run_op(32'h0001_0000, 32'h0002_0000, 3'd2, 1, 32, 33'h0);
        run_op(32'd12345, 32'd678, 3'd2, 0, 32, 33'd8369910);
        run_op(32'd100, 32'd7, 3'd3, 2, 32, 33'd14);
        chk("div_err", {63'b0, rsp_err}, 64'd0);
        run_op(32'd100, 32'd7, 3'd4, 0, 32, 33'd2);
        send(32'd5, 32'd0, 3'd3);
        wait_rsp(lat);
        chk("div0_latency", 64'(lat), 64'd0);
        chk("div0_result", {31'b0, result}, 64'h1_FFFF_FFFF);
        chk("div0_err", {63'b0, rsp_err}, 64'd1);
        ack(1);

        // Reset at EXEC cycle 10 aborts the multiply.
        send(32'd999, 32'd777, 3'd2);
        repeat (9) @(negedge clk);
        reset_high = 1'b1;
        @(negedge clk);
        reset_high = 1'b0;
        chk("abort_req_ready", {63'b0, req_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        chk("abort_no_rsp", 64'(seen), 64'd0);
        run_op(32'd0, 32'd1, 3'd1, 0, 0, 33'h1_FFFF_FFFF);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = $urandom_range(0, 200);
                2: ra = 32'hFFFF_FFFF;
                default: ra = 32'd0;
            endcase
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 200);
                2: rb = 32'hFFFF_FFFF;
                default: rb = 32'd0;
            endcase
            rop = 3'($urandom_range(0, 7));
            send(ra, rb, rop);
            wait_rsp(lat);
            ack($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
